decode_stage_ctrl: RTL and testbench



---
 rtl/rv_pkg.sv | 56 +++++
 rtl/control_decode.sv | 147 ++++++++++++++
 rtl/decode_stage_ctrl.sv | 67 ++++++
 tb/tb_decode_stage_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I/M opcodes, control enums and the decode control bundle
package rv_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MDU  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_ctrl_e;

  typedef enum logic {REG_2, IMM} alu_op_mux_e;
  typedef enum logic [1:0] {ALU, PC_PLUS4, IMM_U, PC_IMM} alu_out_mux_e;
  typedef enum logic {PC_OFFSET, REG_OFFSET} branch_target_mux_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} rw_sz_e;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } mdu_op_e;

  typedef struct packed {
    logic reg_we;
  } wb_ctrl_t;

  typedef struct packed {
    logic   mem_read;
    logic   mem_write;
    rw_sz_e rw_sz;
    logic   ld_unsigned;
  } mem_ctrl_t;

  typedef struct packed {
    wb_ctrl_t           wb_ctrl;
    mem_ctrl_t          mem_ctrl;
    alu_ctrl_e          alu_ctrl;
    alu_op_mux_e        alu_op_mux;
    alu_out_mux_e       alu_out_mux;
    branch_target_mux_e branch_target_mux;
    logic               do_branch;
    logic               is_mdu;
    mdu_op_e            mdu_op;
    logic               illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational RV32I/M instruction to control-bundle decode
module control_decode
  import rv_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // register indices are consumed by the register file, not by this decode
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Base-opcode defaults, per-opcode overrides, then illegal squashes side effects
  always_comb begin
    ctrl                   = '0;
    ctrl.alu_op_mux        = REG_2;
    ctrl.alu_out_mux       = ALU;
    ctrl.branch_target_mux = PC_OFFSET;
    ctrl.alu_ctrl          = ALU_ADD;
    ctrl.mem_ctrl.rw_sz    = WORD;
    ctrl.mdu_op            = MUL;

    if (instr[1:0] != 2'b11) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (opcode)
        OPCODE_LUI: begin
          ctrl.wb_ctrl.reg_we = 1'b1;
          ctrl.alu_out_mux    = IMM_U;
        end
        OPCODE_AUIPC: begin
          ctrl.wb_ctrl.reg_we = 1'b1;
          ctrl.alu_out_mux    = PC_IMM;
        end
        OPCODE_JAL: begin
          ctrl.wb_ctrl.reg_we = 1'b1;
          ctrl.do_branch      = 1'b1;
          ctrl.alu_out_mux    = PC_PLUS4;
        end
        OPCODE_JALR: begin
          ctrl.wb_ctrl.reg_we    = 1'b1;
          ctrl.do_branch         = 1'b1;
          ctrl.alu_out_mux       = PC_PLUS4;
          ctrl.branch_target_mux = REG_OFFSET;
          ctrl.illegal           = (funct3 != 3'b000);
        end
        OPCODE_BRANCH: begin
          ctrl.do_branch = 1'b1;
          case (funct3)
            3'b000:  ctrl.alu_ctrl = ALU_EQ;
            3'b001:  ctrl.alu_ctrl = ALU_NE;
            3'b100:  ctrl.alu_ctrl = ALU_LT;
            3'b101:  ctrl.alu_ctrl = ALU_GE;
            3'b110:  ctrl.alu_ctrl = ALU_LTU;
            3'b111:  ctrl.alu_ctrl = ALU_GEU;
            default: ctrl.illegal  = 1'b1;
          endcase
        end
        OPCODE_LOAD: begin
          ctrl.wb_ctrl.reg_we        = 1'b1;
          ctrl.mem_ctrl.mem_read     = 1'b1;
          ctrl.alu_op_mux            = IMM;
          ctrl.mem_ctrl.ld_unsigned  = funct3[2];
          case (funct3)
            3'b000, 3'b100: ctrl.mem_ctrl.rw_sz = BYTE;
            3'b001, 3'b101: ctrl.mem_ctrl.rw_sz = HALF;
            3'b010:         ctrl.mem_ctrl.rw_sz = WORD;
            default:        ctrl.illegal = 1'b1;
          endcase
        end
        OPCODE_STORE: begin
          ctrl.mem_ctrl.mem_write = 1'b1;
          ctrl.alu_op_mux         = IMM;
          case (funct3)
            3'b000:  ctrl.mem_ctrl.rw_sz = BYTE;
            3'b001:  ctrl.mem_ctrl.rw_sz = HALF;
            3'b010:  ctrl.mem_ctrl.rw_sz = WORD;
            default: ctrl.illegal = 1'b1;
          endcase
        end
        OPCODE_OP_IMM: begin
          ctrl.wb_ctrl.reg_we = 1'b1;
          ctrl.alu_op_mux     = IMM;
          case (funct3)
            3'b000: ctrl.alu_ctrl = ALU_ADD;
            3'b010: ctrl.alu_ctrl = ALU_SLT;
            3'b011: ctrl.alu_ctrl = ALU_SLTU;
            3'b100: ctrl.alu_ctrl = ALU_XOR;
            3'b110: ctrl.alu_ctrl = ALU_OR;
            3'b111: ctrl.alu_ctrl = ALU_AND;
            3'b001: begin
              ctrl.alu_ctrl = ALU_SLL;
              ctrl.illegal  = (funct7 != FUNCT7_BASE);
            end
            default: begin
              if (funct7 == FUNCT7_BASE)     ctrl.alu_ctrl = ALU_SRL;
              else if (funct7 == FUNCT7_ALT) ctrl.alu_ctrl = ALU_SRA;
              else                           ctrl.illegal  = 1'b1;
            end
          endcase
        end
        OPCODE_OP: begin
          ctrl.wb_ctrl.reg_we = 1'b1;
          if (funct7 == FUNCT7_BASE) begin
            case (funct3)
              3'b000:  ctrl.alu_ctrl = ALU_ADD;
              3'b001:  ctrl.alu_ctrl = ALU_SLL;
              3'b010:  ctrl.alu_ctrl = ALU_SLT;
              3'b011:  ctrl.alu_ctrl = ALU_SLTU;
              3'b100:  ctrl.alu_ctrl = ALU_XOR;
              3'b101:  ctrl.alu_ctrl = ALU_SRL;
              3'b110:  ctrl.alu_ctrl = ALU_OR;
              default: ctrl.alu_ctrl = ALU_AND;
            endcase
          end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
            ctrl.alu_ctrl = ALU_SUB;
          end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
            ctrl.alu_ctrl = ALU_SRA;
          end else if (funct7 == FUNCT7_MDU && M_EXT != 0) begin
            ctrl.is_mdu = 1'b1;
            ctrl.mdu_op = mdu_op_e'(funct3);
          end else begin
            ctrl.illegal = 1'b1;
          end
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end

    if (ctrl.illegal) begin
      ctrl.wb_ctrl.reg_we     = 1'b0;
      ctrl.mem_ctrl.mem_read  = 1'b0;
      ctrl.mem_ctrl.mem_write = 1'b0;
      ctrl.do_branch          = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// rtl/decode_stage_ctrl.sv - registered decode stage with handshake, MDU busy stall and flush
module decode_stage_ctrl
  import rv_pkg::*;
#(
  parameter int M_EXT       = 1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [31:0]  i_instr,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_flush,
  output logic         o_valid,
  input  logic         i_ready,
  output ctrl_bundle_t o_ctrl
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int BW      = $clog2(MAX_LAT + 1);
  localparam logic [BW-1:0] MUL_LOAD = BW'(MUL_LATENCY - 1);
  localparam logic [BW-1:0] DIV_LOAD = BW'(DIV_LATENCY - 1);

  ctrl_bundle_t  dec;
  ctrl_bundle_t  ctrl_q;
  logic          valid_q;
  logic [BW-1:0] busy;
  logic          accept;

  control_decode #(.M_EXT(M_EXT)) u_decode (
    .instr (i_instr),
    .ctrl  (dec)
  );

  assign o_ready = (~valid_q | i_ready) & (busy == '0) & ~i_flush;
  assign accept  = i_valid & o_ready;
  assign o_valid = valid_q;
  assign o_ctrl  = ctrl_q;

  // Output register and MDU occupancy counter; flush beats accept and handoff
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      busy    <= '0;
      ctrl_q  <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      busy    <= '0;
    end else begin
      if (accept) begin
        ctrl_q  <= dec;
        valid_q <= 1'b1;
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end

      // funct3[2] separates the DIV/REM class from the MUL class
      if (accept && dec.is_mdu) begin
        busy <= i_instr[14] ? DIV_LOAD : MUL_LOAD;
      end else if (busy != '0) begin
        busy <= busy - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// tb/tb_decode_stage_ctrl.sv - directed self-checking bench for decode_stage_ctrl
module tb_decode_stage_ctrl;
  import rv_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [31:0]  instr;
  logic         in_valid;
  logic         flush;
  logic         out_ready;
  logic         rdy;
  logic         vld;
  ctrl_bundle_t ctrl;
  logic         rdy0;
  logic         vld0;
  ctrl_bundle_t ctrl0;
  ctrl_bundle_t saved;

  int total;
  int bad;
  int n;

  decode_stage_ctrl #(.M_EXT(1), .MUL_LATENCY(3), .DIV_LATENCY(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_instr (instr),
    .i_valid (in_valid),
    .o_ready (rdy),
    .i_flush (flush),
    .o_valid (vld),
    .i_ready (out_ready),
    .o_ctrl  (ctrl)
  );

  decode_stage_ctrl #(.M_EXT(0), .MUL_LATENCY(3), .DIV_LATENCY(32)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_instr (instr),
    .i_valid (in_valid),
    .o_ready (rdy0),
    .i_flush (flush),
    .o_valid (vld0),
    .i_ready (out_ready),
    .o_ctrl  (ctrl0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    instr = 32'h0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // reset
    tick();
    tick();
    check("rst_valid", 64'(vld), 64'd0);
    check("rst_ctrl", 64'(ctrl), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(rdy), 64'd1);

    // ADD, then back-to-back SRAI and BGEU
    instr = 32'h002081B3; in_valid = 1'b1;
    tick();
    check("add_valid", 64'(vld), 64'd1);
    check("add_alu", 64'(ctrl.alu_ctrl), 64'(ALU_ADD));
    check("add_we", 64'(ctrl.wb_ctrl.reg_we), 64'd1);
    check("add_ill", 64'(ctrl.illegal), 64'd0);
    instr = 32'h4030D093;
    tick();
    check("srai_valid", 64'(vld), 64'd1);
    check("srai_alu", 64'(ctrl.alu_ctrl), 64'(ALU_SRA));
    check("srai_mux", 64'(ctrl.alu_op_mux), 64'(IMM));
    instr = 32'h0020F463;
    tick();
    check("bgeu_alu", 64'(ctrl.alu_ctrl), 64'(ALU_GEU));
    check("bgeu_br", 64'(ctrl.do_branch), 64'd1);
    check("bgeu_we", 64'(ctrl.wb_ctrl.reg_we), 64'd0);

    // MUL with latency 3; the M_EXT=0 instance flags it illegal
    instr = 32'h022081B3;
    #1;
    check("mul_ready_pre", 64'(rdy), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("mul_mdu", 64'(ctrl.is_mdu), 64'd1);
    check("mul_op", 64'(ctrl.mdu_op), 64'(MUL));
    check("mul_we", 64'(ctrl.wb_ctrl.reg_we), 64'd1);
    check("mul_rdy_t1", 64'(rdy), 64'd0);
    check("m0_valid", 64'(vld0), 64'd1);
    check("m0_ill", 64'(ctrl0.illegal), 64'd1);
    check("m0_we", 64'(ctrl0.wb_ctrl.reg_we), 64'd0);
    check("m0_mdu", 64'(ctrl0.is_mdu), 64'd0);
    tick();
    check("mul_rdy_t2", 64'(rdy), 64'd0);
    check("mul_drop", 64'(vld), 64'd0);
    tick();
    check("mul_rdy_t3", 64'(rdy), 64'd1);

    // DIVU with latency 32: 31 stalled cycles
    instr = 32'h0220D1B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("divu_op", 64'(ctrl.mdu_op), 64'(DIVU));
    n = 0;
    while (rdy === 1'b0 && n < 40) begin
      n++;
      tick();
    end
    check("divu_stall", 64'(n), 64'd31);
    check("divu_ready", 64'(rdy), 64'd1);

    // backpressure holds SUB while BGEU waits
    instr = 32'h402081B3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    saved = ctrl;
    instr = 32'h0020F463;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ready", 64'(rdy), 64'd0);
      check("bp_valid", 64'(vld), 64'd1);
      check("bp_alu", 64'(ctrl.alu_ctrl), 64'(ALU_SUB));
      check("bp_hold", 64'(ctrl), 64'(saved));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release", 64'(vld), 64'd0);

    // flush during a DIV stall with a held output
    instr = 32'h0220C1B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("fl_held", 64'(vld), 64'd1);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h402081B3;
    #1;
    check("fl_ready", 64'(rdy), 64'd0);
    tick();
    check("fl_valid", 64'(vld), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("fl_ready_after", 64'(rdy), 64'd1);
    tick();
    check("fl_dropped", 64'(vld), 64'd0);

    // illegal instructions and a legal load
    instr = 32'h00000000; in_valid = 1'b1;
    tick();
    check("zero_valid", 64'(vld), 64'd1);
    check("zero_ill", 64'(ctrl.illegal), 64'd1);
    check("zero_en", 64'({ctrl.wb_ctrl.reg_we, ctrl.mem_ctrl.mem_read,
                          ctrl.mem_ctrl.mem_write, ctrl.do_branch}), 64'd0);
    instr = 32'h00003003;
    tick();
    check("ld011_ill", 64'(ctrl.illegal), 64'd1);
    check("ld011_rd", 64'(ctrl.mem_ctrl.mem_read), 64'd0);
    instr = 32'h00002003;
    tick();
    check("lw_ill", 64'(ctrl.illegal), 64'd0);
    check("lw_rd", 64'(ctrl.mem_ctrl.mem_read), 64'd1);
    check("lw_sz", 64'(ctrl.mem_ctrl.rw_sz), 64'(WORD));

    // asynchronous reset abandons a DIVU stall
    instr = 32'h0220D1B3;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(vld), 64'd0);
    check("arst_ctrl", 64'(ctrl), 64'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("arst_ready", 64'(rdy), 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
